// File: rtl/replace_order_out_fifo.sv
// replace_order_out_fifo: first-word-fall-through output buffer for the
// Replace Order decoder. It captures completed decodes and hands them to the
// order-book stage over valid/ready. It also keeps saturating counters for
// entries dropped on a full FIFO and for malformed-packet cycles.
// Optional build macro REPLACE_FIFO_TIMESTAMP_EN stores a 32-bit cycle stamp
// with each entry and presents it on out_timestamp.
module replace_order_out_fifo #(
  parameter int DEPTH        = 8,
  parameter int CNT_W        = 16,
  parameter int REPLACE_TYPE = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       replace_internal_valid,
  input  logic                       replace_packet_invalid,
  input  logic [3:0]                 replace_parsed_type,
  input  logic [63:0]                replace_old_order_ref,
  input  logic [63:0]                replace_new_order_ref,
  input  logic [31:0]                replace_shares,
  input  logic [31:0]                replace_price,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [63:0]                out_old_order_ref,
  output logic [63:0]                out_new_order_ref,
  output logic [31:0]                out_shares,
  output logic [31:0]                out_price,
`ifdef REPLACE_FIFO_TIMESTAMP_EN
  output logic [31:0]                out_timestamp,
`endif
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [CNT_W-1:0]           drop_count,
  output logic [CNT_W-1:0]           invalid_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] drop_q, drop_d, inv_q, inv_d;

  logic [63:0] mem_old_q    [DEPTH];
  logic [63:0] mem_new_q    [DEPTH];
  logic [31:0] mem_shares_q [DEPTH];
  logic [31:0] mem_price_q  [DEPTH];

  logic push, pop, full, empty, accept, drop;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));
  assign push   = replace_internal_valid && (replace_parsed_type == 4'(REPLACE_TYPE));
  assign pop    = !empty && out_ready;
  // A pop frees the head slot on the same edge, so a full FIFO still takes it.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  // Next-state for pointers, occupancy and statistics counters.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    drop_d  = drop_q;
    inv_d   = inv_q;
    if (accept) wptr_d = wptr_q + AW'(1);
    if (pop)    rptr_d = rptr_q + AW'(1);
    if (accept && !pop)      count_d = count_q + CW'(1);
    else if (!accept && pop) count_d = count_q - CW'(1);
    if (drop)                   drop_d = sat_inc(drop_q);
    if (replace_packet_invalid) inv_d  = sat_inc(inv_q);
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
      inv_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      inv_q   <= inv_d;
    end
  end

  // Entry storage; contents are qualified by occupancy so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_old_q[wptr_q]    <= replace_old_order_ref;
      mem_new_q[wptr_q]    <= replace_new_order_ref;
      mem_shares_q[wptr_q] <= replace_shares;
      mem_price_q[wptr_q]  <= replace_price;
    end
  end

`ifdef REPLACE_FIFO_TIMESTAMP_EN
  logic [31:0] cycle_ts_q;
  logic [31:0] mem_ts_q [DEPTH];

  // Free-running cycle stamp, wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cycle_ts_q <= '0;
    else     cycle_ts_q <= cycle_ts_q + 32'd1;
  end

  // Each accepted entry keeps the stamp of its capturing edge.
  always_ff @(posedge clk) begin
    if (accept) mem_ts_q[wptr_q] <= cycle_ts_q;
  end

  assign out_timestamp = empty ? 32'd0 : mem_ts_q[rptr_q];
`endif

  assign out_valid         = !empty;
  assign out_old_order_ref = empty ? 64'd0 : mem_old_q[rptr_q];
  assign out_new_order_ref = empty ? 64'd0 : mem_new_q[rptr_q];
  assign out_shares        = empty ? 32'd0 : mem_shares_q[rptr_q];
  assign out_price         = empty ? 32'd0 : mem_price_q[rptr_q];
  assign fifo_count        = count_q;
  assign drop_count        = drop_q;
  assign invalid_count     = inv_q;

endmodule

// File: tb/tb_replace_order_out_fifo.sv
// Directed bench for replace_order_out_fifo with hand-computed expectations.
module tb_replace_order_out_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv = 1'b0, inv = 1'b0;
  logic [3:0]  ptype = 4'd0;
  logic [63:0] old_ref = '0, new_ref = '0;
  logic [31:0] shares = '0, price = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [63:0] o_old, o_new;
  logic [31:0] o_shares, o_price;
  logic [3:0]  fifo_count;
  logic [15:0] drop_count, invalid_count;
`ifdef REPLACE_FIFO_TIMESTAMP_EN
  logic [31:0] o_ts;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  replace_order_out_fifo #(.DEPTH(8), .CNT_W(16), .REPLACE_TYPE(4)) dut (
    .clk(clk), .rst(rst),
    .replace_internal_valid(iv), .replace_packet_invalid(inv),
    .replace_parsed_type(ptype),
    .replace_old_order_ref(old_ref), .replace_new_order_ref(new_ref),
    .replace_shares(shares), .replace_price(price),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_old_order_ref(o_old), .out_new_order_ref(o_new),
    .out_shares(o_shares), .out_price(o_price),
`ifdef REPLACE_FIFO_TIMESTAMP_EN
    .out_timestamp(o_ts),
`endif
    .fifo_count(fifo_count), .drop_count(drop_count), .invalid_count(invalid_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic [63:0] nref);
    iv = 1'b1; ptype = 4'd4; new_ref = nref; old_ref = nref + 64'h100;
    shares = 32'd10; price = 32'd20;
  endtask

  logic [63:0] exp_seq [8];

  initial begin
    // Reset state
    #2;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_count", fifo_count, 0);
    check_eq("rst_drop", drop_count, 0);
    check_eq("rst_inv", invalid_count, 0);
    check_eq("rst_data", o_new, 0);
    tick();
    rst = 1'b0;

    // Single push with consumer ready
    iv = 1'b1; ptype = 4'd4; old_ref = 64'h1; new_ref = 64'h2;
    shares = 32'd100; price = 32'h0001_86A0; out_ready = 1'b1;
    tick();
    iv = 1'b0;
    check_eq("single_valid", out_valid, 1);
    check_eq("single_old", o_old, 64'h1);
    check_eq("single_new", o_new, 64'h2);
    check_eq("single_shares", o_shares, 100);
    check_eq("single_price", o_price, 32'h0001_86A0);
    check_eq("single_count", fifo_count, 1);
    tick();
    check_eq("single_gone", out_valid, 0);
    check_eq("single_count0", fifo_count, 0);
    check_eq("single_zero", o_new, 0);

    // Backpressure fill: 10 pushes into 8 slots
    out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      set_push(64'(i));
      tick();
    end
    iv = 1'b0;
    check_eq("fill_count", fifo_count, 8);
    check_eq("fill_drop", drop_count, 2);
    tick(); tick();
    check_eq("stall_stable", o_new, 1);
    check_eq("stall_old", o_old, 64'h101);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check_eq("drain_valid", out_valid, 1);
      check_eq("drain_order", o_new, 64'(i));
      tick();
    end
    check_eq("drain_empty", out_valid, 0);
    // Reading an empty FIFO must not move the pointers
    tick(); tick();
    check_eq("empty_read_count", fifo_count, 0);

    // Full with simultaneous push and pop
    out_ready = 1'b0;
    for (int i = 11; i <= 18; i++) begin
      set_push(64'(i));
      tick();
    end
    check_eq("full2_count", fifo_count, 8);
    set_push(64'd99);
    out_ready = 1'b1;
    tick();
    iv = 1'b0;
    check_eq("fullpp_count", fifo_count, 8);
    check_eq("fullpp_drop", drop_count, 2);
    exp_seq = '{64'd12, 64'd13, 64'd14, 64'd15, 64'd16, 64'd17, 64'd18, 64'd99};
    for (int i = 0; i < 8; i++) begin
      check_eq("fullpp_order", o_new, exp_seq[i]);
      tick();
    end
    check_eq("fullpp_empty", out_valid, 0);

    // Type filter plus invalid flag
    iv = 1'b1; ptype = 4'd1; inv = 1'b1;
    tick();
    iv = 1'b0; inv = 1'b0;
    check_eq("filter_count", fifo_count, 0);
    check_eq("filter_valid", out_valid, 0);
    check_eq("filter_inv", invalid_count, 1);
    // Valid push and invalid flag together
    set_push(64'd55); inv = 1'b1;
    tick();
    iv = 1'b0; inv = 1'b0;
    check_eq("both_new", o_new, 55);
    check_eq("both_inv", invalid_count, 2);
    tick();
    check_eq("both_drained", fifo_count, 0);
    inv = 1'b1;
    repeat (70000) tick();
    inv = 1'b0;
    check_eq("inv_sat", invalid_count, 16'hFFFF);

    // Asynchronous reset between edges
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      set_push(64'(40 + i));
      tick();
    end
    iv = 1'b0;
    check_eq("pre_rst_count", fifo_count, 3);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", out_valid, 0);
    check_eq("arst_count", fifo_count, 0);
    check_eq("arst_drop", drop_count, 0);
    check_eq("arst_inv", invalid_count, 0);
    check_eq("arst_data", o_new, 0);
    rst = 1'b0;
    set_push(64'd77);
    out_ready = 1'b1;
    tick();
    iv = 1'b0;
    check_eq("post_rst_valid", out_valid, 1);
    check_eq("post_rst_new", o_new, 77);
    tick();
    check_eq("post_rst_empty", out_valid, 0);

`ifdef REPLACE_FIFO_TIMESTAMP_EN
    // Stamps: counter is 0 right after reset and counts each edge
    rst = 1'b1;
    #2;
    rst = 1'b0;
    out_ready = 1'b0;
    repeat (5) tick();
    set_push(64'd1);
    tick();
    iv = 1'b0;
    repeat (3) tick();
    set_push(64'd2);
    tick();
    iv = 1'b0;
    check_eq("ts_first", o_ts, 5);
    out_ready = 1'b1;
    tick();
    check_eq("ts_second", o_ts, 9);
    tick();
    check_eq("ts_empty", o_ts, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
